// File: rtl/cpu_debug_ctrl_if.sv
// cpu_debug_ctrl_if: monitor-side register window bus (address, write strobe, data in/out, window select).
interface cpu_debug_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] A;
    logic              write;
    logic [7:0]        Din;
    logic [7:0]        Dout;
    logic              win_sel;

    modport master (output A, output write, output Din, input Dout, input win_sel);
    modport slave  (input A, input write, input Din, output Dout, output win_sel);
endinterface

// File: rtl/cpu_debug_ctrl.sv
// cpu_debug_ctrl: 6502 halt/step/breakpoint controller stopping the CPU with a timed NMI pulse.
// Define CPU_DEBUG_PASSCOUNT_EN to add an 8-bit pass counter per breakpoint at window offset +3.
module cpu_debug_ctrl #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned WIN_BASE = 'hE0,
    parameter int unsigned NUM_BP   = 2,
    parameter int unsigned STEP_W   = 8,
    parameter int unsigned NMI_LEN  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    cpu_debug_ctrl_if.slave bus,
    input  logic            sync,
    input  logic [15:0]     cpu_addr,
    input  logic            b_step,
    input  logic            b_runhalt,
    input  logic            b_reset,
    output logic            nmiN,
    output logic            stopped,
    output logic [7:0]      acc,
    output logic [7:0]      x,
    output logic [7:0]      y,
    output logic [7:0]      sp,
    output logic [7:0]      sr,
    output logic [15:0]     pc
);
    localparam int unsigned WIN_SIZE = 16 + 4 * NUM_BP;
    localparam int unsigned CNT_W    = $clog2(NMI_LEN + 1);
    localparam int unsigned SC_W     = STEP_W + 1;

    typedef enum logic [2:0] {ST_RUN, ST_STOP, ST_STEPARMED, ST_STEPWAIT, ST_RESETSTEP} state_t;

    state_t              state;
    logic [SC_W-1:0]     sc;
    logic [SC_W-1:0]     tgt;
    logic [STEP_W-1:0]   step_cnt;
    logic [CNT_W-1:0]    nmi_cnt;
    logic [2:0]          sync_sr;
    logic                sync_rise;
    logic [ADDR_W-1:0]   off;
    logic                wr_c, stat_wr_c, resume_c;
    logic [7:0]          rd_c;
    logic [7:0]          dout_q;
    logic [15:0]         bp_addr [NUM_BP];
    logic [NUM_BP-1:0]   bp_en;
    logic                bp_hit_v;
    logic [2:0]          bp_idx;
    logic                bp_stop_c, check_c, bp_fire_c, stop_req_c;
    logic [2:0]          bp_idx_c;
`ifdef CPU_DEBUG_PASSCOUNT_EN
    logic [7:0]          bp_pass [NUM_BP];
    logic [NUM_BP-1:0]   pass_dec_c;
`endif

    assign bus.win_sel = (32'(bus.A) >= WIN_BASE) && (32'(bus.A) < WIN_BASE + WIN_SIZE);
    assign off         = ADDR_W'(32'(bus.A) - WIN_BASE);
    assign wr_c        = bus.write & bus.win_sel;
    assign stat_wr_c   = wr_c && (off == ADDR_W'(7));
    assign resume_c    = stat_wr_c & bus.Din[0];
    assign bus.Dout    = dout_q;

    // Two-flop synchroniser plus edge detector on the CPU SYNC line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_sr <= '0;
        else        sync_sr <= {sync_sr[1:0], sync};
    end
    assign sync_rise = sync_sr[1] & ~sync_sr[2];

    // Breakpoint compare; descending scan so the lowest stopping index wins
    always_comb begin
        bp_stop_c = 1'b0;
        bp_idx_c  = '0;
`ifdef CPU_DEBUG_PASSCOUNT_EN
        pass_dec_c = '0;
`endif
        for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
            if (bp_en[i] && (cpu_addr == bp_addr[i])) begin
`ifdef CPU_DEBUG_PASSCOUNT_EN
                if (bp_pass[i] != 8'd0) begin
                    pass_dec_c[i] = 1'b1;
                end else begin
                    bp_stop_c = 1'b1;
                    bp_idx_c  = 3'(i);
                end
`else
                bp_stop_c = 1'b1;
                bp_idx_c  = 3'(i);
`endif
            end
        end
    end

    assign check_c   = sync_rise && ((state == ST_RUN) || ((state == ST_STEPWAIT) && !b_reset));
    assign bp_fire_c = check_c & bp_stop_c;
    assign tgt       = (step_cnt == '0) ? SC_W'(1) : {1'b0, step_cnt};

    always_comb begin
        stop_req_c = 1'b0;
        unique case (state)
            ST_RUN:       stop_req_c = b_step | b_runhalt | bp_fire_c;
            ST_STEPWAIT:  stop_req_c = !b_reset && sync_rise && (bp_stop_c || (sc == tgt));
            ST_RESETSTEP: stop_req_c = !b_reset && sync_rise;
            default:      stop_req_c = 1'b0;
        endcase
    end

    // NMI pulse generator; a request while the pulse is active is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmiN    <= 1'b1;
            nmi_cnt <= '0;
        end else if (stop_req_c && nmiN) begin
            nmiN    <= 1'b0;
            nmi_cnt <= CNT_W'(NMI_LEN - 1);
        end else if (!nmiN) begin
            if (nmi_cnt == '0) nmiN <= 1'b1;
            else               nmi_cnt <= nmi_cnt - CNT_W'(1);
        end
    end

    // Debug FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            stopped <= 1'b0;
            sc      <= '0;
        end else begin
            unique case (state)
                ST_RUN: if (stop_req_c) begin
                    state <= ST_STOP; stopped <= 1'b1;
                end
                ST_STOP: begin
                    if (b_reset) begin
                        state <= ST_RESETSTEP; stopped <= 1'b0; sc <= '0;
                    end else if (b_runhalt) begin
                        state <= ST_RUN; stopped <= 1'b0;
                    end else if (b_step) begin
                        state <= ST_STEPARMED; stopped <= 1'b0;
                    end
                end
                ST_STEPARMED: begin
                    if (b_reset)       state <= ST_RUN;
                    else if (resume_c) begin state <= ST_STEPWAIT; sc <= '0; end
                end
                ST_STEPWAIT: begin
                    if (b_reset)         state <= ST_RUN;
                    else if (stop_req_c) begin state <= ST_STOP; stopped <= 1'b1; end
                    else if (sync_rise)  sc <= sc + SC_W'(1);
                end
                ST_RESETSTEP: begin
                    if (b_reset)         state <= ST_RUN;
                    else if (stop_req_c) begin state <= ST_STOP; stopped <= 1'b1; end
                end
                default: begin
                    state <= ST_RUN; stopped <= 1'b0;
                end
            endcase
        end
    end

    // Window read mux; out-of-window addresses read 0
    always_comb begin
        rd_c = 8'h00;
        case (off)
            ADDR_W'(0): rd_c = acc;
            ADDR_W'(1): rd_c = x;
            ADDR_W'(2): rd_c = y;
            ADDR_W'(3): rd_c = sp;
            ADDR_W'(4): rd_c = pc[7:0];
            ADDR_W'(5): rd_c = pc[15:8];
            ADDR_W'(6): rd_c = sr;
            ADDR_W'(7): rd_c = {bp_hit_v, stopped, 3'b000, bp_idx};
            ADDR_W'(8): rd_c = 8'(step_cnt);
            default:    rd_c = 8'h00;
        endcase
        for (int i = 0; i < int'(NUM_BP); i++) begin
            if (off == ADDR_W'(16 + 4 * i)) rd_c = bp_addr[i][7:0];
            if (off == ADDR_W'(17 + 4 * i)) rd_c = bp_addr[i][15:8];
            if (off == ADDR_W'(18 + 4 * i)) rd_c = {7'b0, bp_en[i]};
`ifdef CPU_DEBUG_PASSCOUNT_EN
            if (off == ADDR_W'(19 + 4 * i)) rd_c = bp_pass[i];
`endif
        end
        if (!bus.win_sel) rd_c = 8'h00;
    end

    // Window registers; reads see the pre-write value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0; acc <= '0; x <= '0; y <= '0; sp <= '0; sr <= '0; pc <= '0;
            step_cnt <= '0; bp_en <= '0; bp_hit_v <= 1'b0; bp_idx <= '0;
            for (int i = 0; i < int'(NUM_BP); i++) begin
                bp_addr[i] <= '0;
`ifdef CPU_DEBUG_PASSCOUNT_EN
                bp_pass[i] <= '0;
`endif
            end
        end else begin
            dout_q <= rd_c;
            if (wr_c) begin
                case (off)
                    ADDR_W'(0): acc           <= bus.Din;
                    ADDR_W'(1): x             <= bus.Din;
                    ADDR_W'(2): y             <= bus.Din;
                    ADDR_W'(3): sp            <= bus.Din;
                    ADDR_W'(4): pc[7:0]       <= bus.Din;
                    ADDR_W'(5): pc[15:8]      <= bus.Din;
                    ADDR_W'(6): sr            <= bus.Din;
                    ADDR_W'(8): step_cnt      <= STEP_W'(bus.Din);
                    default: ;
                endcase
            end
            for (int i = 0; i < int'(NUM_BP); i++) begin
                if (wr_c && (off == ADDR_W'(16 + 4 * i))) bp_addr[i][7:0]  <= bus.Din;
                if (wr_c && (off == ADDR_W'(17 + 4 * i))) bp_addr[i][15:8] <= bus.Din;
                if (wr_c && (off == ADDR_W'(18 + 4 * i))) bp_en[i]         <= bus.Din[0];
`ifdef CPU_DEBUG_PASSCOUNT_EN
                if (wr_c && (off == ADDR_W'(19 + 4 * i))) bp_pass[i] <= bus.Din;
                else if (check_c && pass_dec_c[i])       bp_pass[i] <= bp_pass[i] - 8'd1;
`endif
            end
            if (bp_fire_c) begin
                bp_hit_v <= 1'b1;
                bp_idx   <= bp_idx_c;
            end else if (stat_wr_c) begin
                bp_hit_v <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// tb_cpu_debug_ctrl: directed stimulus with scoreboard queues for window reads and NMI pulses.
module tb_cpu_debug_ctrl;
    localparam int unsigned NMI_LEN = 16;

    typedef struct {
        string      nm;
        logic [7:0] val;
    } rd_item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        b_step = 1'b0, b_runhalt = 1'b0, b_reset = 1'b0;
    logic        nmiN, stopped;
    logic [7:0]  acc, x, y, sp, sr;
    logic [15:0] pc;

    logic        rd_en = 1'b0;
    logic        rd_vld = 1'b0;
    rd_item_t    rd_q[$];
    int          nmi_q[$];
    int          nmi_falls = 0;
    int          tests = 0, errors = 0;

    cpu_debug_ctrl_if #(.ADDR_W(8)) bus ();

    cpu_debug_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .sync(sync), .cpu_addr(cpu_addr),
        .b_step(b_step), .b_runhalt(b_runhalt), .b_reset(b_reset),
        .nmiN(nmiN), .stopped(stopped),
        .acc(acc), .x(x), .y(y), .sp(sp), .sr(sr), .pc(pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Read-data monitor: Dout is due on the cycle after a read address was presented
    always @(posedge clk) rd_vld <= rd_en;
    initial begin : rd_mon
        rd_item_t it;
        forever begin
            @(negedge clk);
            if (rd_vld) begin
                if (rd_q.size() == 0) check("rd_unexpected", 32'(bus.Dout), 32'hFFFF_FFFF);
                else begin
                    it = rd_q.pop_front();
                    check(it.nm, 32'(bus.Dout), 32'(it.val));
                end
            end
        end
    end

    // NMI monitor: measures each low pulse and matches it against the expected queue
    initial begin : nmi_mon
        int   low_cnt;
        logic prev;
        low_cnt = 0;
        prev    = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                low_cnt = 0;
                prev    = 1'b1;
            end else if (!nmiN) begin
                if (prev) nmi_falls++;
                low_cnt++;
                prev = 1'b0;
            end else begin
                if (low_cnt > 0) begin
                    if (nmi_q.size() == 0) check("nmi_unexpected", 32'(low_cnt), 32'd0);
                    else                   check("nmi_len", 32'(low_cnt), 32'(nmi_q.pop_front()));
                    low_cnt = 0;
                end
                prev = 1'b1;
            end
        end
    end

    task automatic bus_op(input logic [7:0] a, input logic w, input logic [7:0] d,
                          input logic chk, input logic [7:0] exp, input string nm);
        @(negedge clk);
        bus.A = a; bus.write = w; bus.Din = d; rd_en = chk;
        if (chk) rd_q.push_back('{nm, exp});
        @(posedge clk); #1;
        bus.write = 1'b0; rd_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus_op(a, 1'b1, d, 1'b0, 8'h00, "");
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
        bus_op(a, 1'b0, 8'h00, 1'b1, exp, nm);
    endtask

    // bits: {reset, runhalt, step}
    task automatic press(input logic [2:0] b);
        @(negedge clk);
        {b_reset, b_runhalt, b_step} = b;
        @(posedge clk); #1;
        {b_reset, b_runhalt, b_step} = 3'b000;
    endtask

    task automatic cpu_op(input logic [15:0] a);
        @(negedge clk);
        cpu_addr = a; sync = 1'b1;
        repeat (4) @(negedge clk);
        sync = 1'b0;
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : main
        int nf;
        bus.A = '0; bus.write = 1'b0; bus.Din = '0;

        // Reset state
        idle(3);
        check("rst_nmiN", 32'(nmiN), 32'd1);
        check("rst_stopped", 32'(stopped), 32'd0);
        check("rst_dout", 32'(bus.Dout), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Window boundaries
        @(negedge clk);
        bus.A = 8'hE0; #1 check("win_e0", 32'(bus.win_sel), 32'd1);
        bus.A = 8'hF7; #1 check("win_f7", 32'(bus.win_sel), 32'd1);
        bus.A = 8'hF8; #1 check("win_f8", 32'(bus.win_sel), 32'd0);
        bus.A = 8'hDF; #1 check("win_df", 32'(bus.win_sel), 32'd0);

        // Register access
        wr(8'hE1, 8'h5A);
        check("x_out", 32'(x), 32'h5A);
        rd(8'hE1, 8'h5A, "rd_x");
        rd(8'hEE, 8'h00, "rd_unmapped_ee");
        wr(8'hE4, 8'h34);
        wr(8'hE5, 8'h12);
        check("pc_out", 32'(pc), 32'h1234);
        bus_op(8'hE2, 1'b1, 8'h77, 1'b1, 8'h00, "rd_y_same_cycle_old");
        rd(8'hE2, 8'h77, "rd_y_new");
        wr(8'hE9, 8'hFF);
        rd(8'hE9, 8'h00, "rd_unmapped_e9");
        rd(8'h10, 8'h00, "rd_outside");

        // Halt from RUN
        nf = nmi_falls;
        nmi_q.push_back(NMI_LEN);
        press(3'b010);
        check("halt_nmi_low", 32'(nmiN), 32'd0);
        check("halt_stopped", 32'(stopped), 32'd1);
        idle(20);
        check("halt_falls", 32'(nmi_falls), 32'(nf + 1));
        rd(8'hE7, 8'h40, "status_halt");

        // Step with step_cnt=3: stop on the 4th syncRise
        wr(8'hE8, 8'h03);
        press(3'b001);
        check("armed_stopped", 32'(stopped), 32'd0);
        nf = nmi_falls;
        nmi_q.push_back(NMI_LEN);
        wr(8'hE7, 8'h01);
        repeat (3) cpu_op(16'h0100);
        check("step3_no_nmi", 32'(nmi_falls), 32'(nf));
        check("step3_running", 32'(stopped), 32'd0);
        cpu_op(16'h0100);
        check("step4_nmi", 32'(nmi_falls), 32'(nf + 1));
        check("step4_stopped", 32'(stopped), 32'd1);
        idle(20);

        // Breakpoint 0 at 0x1234
        wr(8'hF0, 8'h34);
        wr(8'hF1, 8'h12);
        wr(8'hF2, 8'h01);
        press(3'b010);
        check("bp_run", 32'(stopped), 32'd0);
        nf = nmi_falls;
        cpu_op(16'h1000);
        check("bp_miss", 32'(nmi_falls), 32'(nf));
        nmi_q.push_back(NMI_LEN);
        cpu_op(16'h1234);
        check("bp_hit_stopped", 32'(stopped), 32'd1);
        idle(20);
        rd(8'hE7, 8'hC0, "status_bp0");
        rd(8'hF0, 8'h34, "rd_bp0_lo");
        rd(8'hF2, 8'h01, "rd_bp0_ctrl");
        rd(8'hF3, 8'h00, "rd_bp0_pass");
        wr(8'hE7, 8'h00);
        rd(8'hE7, 8'h40, "status_clear");

        // Two breakpoints on the same address: lowest index wins, one pulse
        wr(8'hF0, 8'h00);
        wr(8'hF1, 8'h20);
        wr(8'hF4, 8'h00);
        wr(8'hF5, 8'h20);
        wr(8'hF6, 8'h01);
        press(3'b010);
        nf = nmi_falls;
        nmi_q.push_back(NMI_LEN);
        cpu_op(16'h2000);
        idle(20);
        check("dual_one_pulse", 32'(nmi_falls), 32'(nf + 1));
        rd(8'hE7, 8'hC0, "status_dual");
        wr(8'hF2, 8'h00);
        wr(8'hE7, 8'h00);
        press(3'b010);
        nmi_q.push_back(NMI_LEN);
        cpu_op(16'h2000);
        idle(20);
        rd(8'hE7, 8'hC1, "status_bp1");

        // Reset-step whose NMI request lands inside an active pulse and is dropped
        press(3'b010);
        nf = nmi_falls;
        nmi_q.push_back(NMI_LEN);
        press(3'b010);
        press(3'b100);
        check("resetstep_stopped", 32'(stopped), 32'd0);
        cpu_op(16'h3000);
        check("resetstep_stop", 32'(stopped), 32'd1);
        check("resetstep_dropped", 32'(nmi_falls), 32'(nf + 1));
        idle(20);

        // step_cnt=0 behaves as 1: stop on the 2nd syncRise
        wr(8'hE8, 8'h00);
        press(3'b001);
        nf = nmi_falls;
        nmi_q.push_back(NMI_LEN);
        wr(8'hE7, 8'h01);
        cpu_op(16'h3000);
        check("step0_first", 32'(nmi_falls), 32'(nf));
        cpu_op(16'h3000);
        check("step0_second", 32'(nmi_falls), 32'(nf + 1));
        check("step0_stopped", 32'(stopped), 32'd1);
        idle(20);

        // Async reset in the middle of a pulse
        press(3'b010);
        nmi_q.push_back(NMI_LEN);
        press(3'b010);
        idle(5);
        @(posedge clk); #2;
        nmi_q.delete();
        rst_n = 1'b0;
        #1;
        check("midrst_nmiN", 32'(nmiN), 32'd1);
        check("midrst_stopped", 32'(stopped), 32'd0);
        check("midrst_x", 32'(x), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd(8'hE7, 8'h00, "status_after_rst");
        rd(8'hF6, 8'h00, "bp1_en_after_rst");
        rd(8'hE8, 8'h00, "step_cnt_after_rst");

`ifdef CPU_DEBUG_PASSCOUNT_EN
        // Pass count 2: third hit stops
        wr(8'hF0, 8'h00);
        wr(8'hF1, 8'h40);
        wr(8'hF2, 8'h01);
        wr(8'hF3, 8'h02);
        nf = nmi_falls;
        cpu_op(16'h4000);
        cpu_op(16'h4000);
        check("pass_no_stop", 32'(nmi_falls), 32'(nf));
        rd(8'hF3, 8'h00, "pass_counted_down");
        nmi_q.push_back(NMI_LEN);
        cpu_op(16'h4000);
        check("pass_third_stop", 32'(stopped), 32'd1);
        idle(20);
        rd(8'hE7, 8'hC0, "status_pass");
`else
        wr(8'hF3, 8'h55);
        rd(8'hF3, 8'h00, "pass_absent");
        nf = nmi_falls;
        wr(8'hF0, 8'h00);
        wr(8'hF1, 8'h40);
        wr(8'hF2, 8'h01);
        nmi_q.push_back(NMI_LEN);
        cpu_op(16'h4000);
        check("first_hit_stop", 32'(nmi_falls), 32'(nf + 1));
        idle(20);
`endif

        idle(3);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("nmi_q_drained", 32'(nmi_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
